// File: rtl/mem_vio_detect.sv
// mem_vio_detect: tracks issued, uncommitted loads and flags any issued store that overlaps a younger one.
// Optional saturating violation counter on o_vio_count, enabled by defining MEM_VIO_STAT_EN.
module mem_vio_detect #(
    parameter int LDT_ENTRIES  = 16,
    parameter int PADDR_WIDTH  = 40,
    parameter int FOLDPC_WIDTH = 10,
    parameter int ROBIDX_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_ld_vld,
    input  logic [ROBIDX_WIDTH-1:0] i_ld_robIdx,
    input  logic [PADDR_WIDTH-1:0]  i_ld_paddr,
    input  logic [7:0]              i_ld_mask,
    input  logic [FOLDPC_WIDTH-1:0] i_ld_foldpc,
    output logic                    o_full,
    input  logic                    i_st_vld,
    input  logic [ROBIDX_WIDTH-1:0] i_st_robIdx,
    input  logic [PADDR_WIDTH-1:0]  i_st_paddr,
    input  logic [7:0]              i_st_mask,
    input  logic [FOLDPC_WIDTH-1:0] i_st_foldpc,
    input  logic                    i_commit_vld,
    input  logic [ROBIDX_WIDTH-1:0] i_commit_robIdx,
    input  logic                    i_squash,
    input  logic [ROBIDX_WIDTH-1:0] i_squash_robIdx,
    output logic                    o_violation,
    output logic [FOLDPC_WIDTH-1:0] o_vio_store_foldpc,
    output logic [FOLDPC_WIDTH-1:0] o_vio_load_foldpc,
    output logic [ROBIDX_WIDTH-1:0] o_vio_load_robIdx,
    output logic [31:0]             o_vio_count
);
    localparam int IW = (LDT_ENTRIES > 1) ? $clog2(LDT_ENTRIES) : 1;
    localparam int AW = PADDR_WIDTH - 3;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        WAIT_FLUSH = 1'b1
    } state_t;

    // Wrap-aware age compare: true when a is older than b.
    function automatic logic is_older(input logic [ROBIDX_WIDTH-1:0] a,
                                      input logic [ROBIDX_WIDTH-1:0] b);
        logic r;
        if (a[ROBIDX_WIDTH-1] == b[ROBIDX_WIDTH-1]) begin
            r = (a[ROBIDX_WIDTH-2:0] < b[ROBIDX_WIDTH-2:0]);
        end else begin
            r = (a[ROBIDX_WIDTH-2:0] > b[ROBIDX_WIDTH-2:0]);
        end
        return r;
    endfunction

    logic [LDT_ENTRIES-1:0]  valid_r;
    logic [AW-1:0]           paddr_r [LDT_ENTRIES];
    logic [7:0]              mask_r  [LDT_ENTRIES];
    logic [ROBIDX_WIDTH-1:0] rob_r   [LDT_ENTRIES];
    logic [FOLDPC_WIDTH-1:0] fpc_r   [LDT_ENTRIES];
    logic                    full_r;
    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    vio_r;
    logic [FOLDPC_WIDTH-1:0] vio_st_fpc_r;
    logic [FOLDPC_WIDTH-1:0] vio_ld_fpc_r;
    logic [ROBIDX_WIDTH-1:0] vio_ld_rob_r;

    logic [LDT_ENTRIES-1:0]  cm_s;
    logic [LDT_ENTRIES-1:0]  sq_s;
    logic [LDT_ENTRIES-1:0]  ent_hit_s;
    logic [LDT_ENTRIES-1:0]  valid_nxt_s;
    logic [IW-1:0]           free_idx_s;
    logic                    free_hit_s;
    logic                    ld_alive_s;
    logic                    ld_ins_s;
    logic                    st_eff_s;
    logic                    inc_hit_s;
    logic                    hit_s;
    logic                    take_s;
    logic [ROBIDX_WIDTH-1:0] sel_rob_s;
    logic [FOLDPC_WIDTH-1:0] sel_fpc_s;
    logic                    report_s;
    logic                    commit_hit_s;
    logic                    paddr_lsb_unused_s;

    assign paddr_lsb_unused_s = ^{i_ld_paddr[2:0], i_st_paddr[2:0]};

    // Per-entry commit-clear and squash-kill vectors, plus per-entry store match.
    always_comb begin
        cm_s      = '0;
        sq_s      = '0;
        ent_hit_s = '0;
        for (int i = 0; i < LDT_ENTRIES; i++) begin
            cm_s[i]      = i_commit_vld && valid_r[i] && (rob_r[i] == i_commit_robIdx);
            sq_s[i]      = i_squash && !is_older(rob_r[i], i_squash_robIdx);
            ent_hit_s[i] = valid_r[i] && !sq_s[i] && is_older(i_st_robIdx, rob_r[i]) &&
                           (paddr_r[i] == i_st_paddr[PADDR_WIDTH-1:3]) &&
                           ((mask_r[i] & i_st_mask) != 8'h00);
        end
    end

    // Incoming load/store qualification and oldest-victim selection.
    always_comb begin
        ld_alive_s = i_ld_vld && (!i_squash || is_older(i_ld_robIdx, i_squash_robIdx));
        st_eff_s   = i_st_vld && (!i_squash || is_older(i_st_robIdx, i_squash_robIdx));
        inc_hit_s  = ld_alive_s && is_older(i_st_robIdx, i_ld_robIdx) &&
                     (i_ld_paddr[PADDR_WIDTH-1:3] == i_st_paddr[PADDR_WIDTH-1:3]) &&
                     ((i_ld_mask & i_st_mask) != 8'h00);
        hit_s      = inc_hit_s;
        sel_rob_s  = i_ld_robIdx;
        sel_fpc_s  = i_ld_foldpc;
        take_s     = 1'b0;
        for (int i = 0; i < LDT_ENTRIES; i++) begin
            take_s    = ent_hit_s[i] && (!hit_s || is_older(rob_r[i], sel_rob_s));
            sel_rob_s = take_s ? rob_r[i] : sel_rob_s;
            sel_fpc_s = take_s ? fpc_r[i] : sel_fpc_s;
            hit_s     = hit_s | take_s;
        end
        // A flush in the same cycle outranks any report.
        report_s = st_eff_s && hit_s && (state_r == IDLE) && !i_squash;
    end

    // Next valid vector: free slot is taken from pre-commit state so a freed entry waits a cycle.
    always_comb begin
        free_idx_s = '0;
        free_hit_s = ~&valid_r;
        for (int i = LDT_ENTRIES - 1; i >= 0; i--) begin
            free_idx_s = !valid_r[i] ? IW'(i) : free_idx_s;
        end
        commit_hit_s = |cm_s;
        ld_ins_s     = ld_alive_s && !full_r && free_hit_s;
        valid_nxt_s  = (valid_r & ~cm_s & ~sq_s) |
                       (ld_ins_s ? ({{(LDT_ENTRIES-1){1'b0}}, 1'b1} << free_idx_s) : '0);
    end

    // Violation FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (report_s) state_nxt_s = WAIT_FLUSH;
                else          state_nxt_s = IDLE;
            end
            WAIT_FLUSH: begin
                if (i_squash) state_nxt_s = IDLE;
                else          state_nxt_s = WAIT_FLUSH;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control state: valid bits, full flag, FSM and report registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r      <= '0;
            full_r       <= 1'b0;
            state_r      <= IDLE;
            vio_r        <= 1'b0;
            vio_st_fpc_r <= '0;
            vio_ld_fpc_r <= '0;
            vio_ld_rob_r <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            full_r  <= &valid_nxt_s;
            state_r <= state_nxt_s;
            vio_r   <= report_s;
            if (report_s) begin
                vio_st_fpc_r <= i_st_foldpc;
                vio_ld_fpc_r <= sel_fpc_s;
                vio_ld_rob_r <= sel_rob_s;
            end
        end
    end

    // Entry payload; qualified by valid_r so it needs no reset.
    always_ff @(posedge clk) begin
        if (ld_ins_s) begin
            paddr_r[free_idx_s] <= i_ld_paddr[PADDR_WIDTH-1:3];
            mask_r[free_idx_s]  <= i_ld_mask;
            rob_r[free_idx_s]   <= i_ld_robIdx;
            fpc_r[free_idx_s]   <= i_ld_foldpc;
        end
    end

`ifdef MEM_VIO_STAT_EN
    logic [31:0] vio_count_r;

    // Saturating count of reported violations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vio_count_r <= 32'd0;
        end else if (report_s && (vio_count_r != 32'hFFFF_FFFF)) begin
            vio_count_r <= vio_count_r + 32'd1;
        end
    end

    assign o_vio_count = vio_count_r;
`else
    assign o_vio_count = 32'd0;
`endif

    assign o_full             = full_r;
    assign o_violation        = vio_r;
    assign o_vio_store_foldpc = vio_st_fpc_r;
    assign o_vio_load_foldpc  = vio_ld_fpc_r;
    assign o_vio_load_robIdx  = vio_ld_rob_r;

    mem_vio_detect_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .ld_vld       (i_ld_vld),
        .full         (full_r),
        .commit_vld   (i_commit_vld),
        .commit_hit   (commit_hit_s)
    );

endmodule

// Protocol checks for the load pipe and commit interface.
module mem_vio_detect_chk (
    input logic clk,
    input logic rst,
    input logic ld_vld,
    input logic full,
    input logic commit_vld,
    input logic commit_hit
);
    a_no_insert_when_full: assert property (@(posedge clk) disable iff (!rst) !(ld_vld && full));
    a_commit_hits_entry:   assert property (@(posedge clk) disable iff (!rst) (commit_vld |-> commit_hit));
endmodule

// File: tb/tb_mem_vio_detect.sv
// Directed scoreboard bench for mem_vio_detect; expected reports are queued per cycle and checked after the edge.
module tb_mem_vio_detect;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_ld_vld;
    logic [6:0]  i_ld_robIdx;
    logic [39:0] i_ld_paddr;
    logic [7:0]  i_ld_mask;
    logic [9:0]  i_ld_foldpc;
    logic        o_full;
    logic        i_st_vld;
    logic [6:0]  i_st_robIdx;
    logic [39:0] i_st_paddr;
    logic [7:0]  i_st_mask;
    logic [9:0]  i_st_foldpc;
    logic        i_commit_vld;
    logic [6:0]  i_commit_robIdx;
    logic        i_squash;
    logic [6:0]  i_squash_robIdx;
    logic        o_violation;
    logic [9:0]  o_vio_store_foldpc;
    logic [9:0]  o_vio_load_foldpc;
    logic [6:0]  o_vio_load_robIdx;
    logic [31:0] o_vio_count;

    typedef struct packed {
        logic       vio;
        logic [9:0] sfpc;
        logic [9:0] lfpc;
        logic [6:0] lrob;
    } exp_t;

    exp_t sb_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;
    localparam exp_t NOV = '0;

    mem_vio_detect dut (
        .clk(clk), .rst(rst),
        .i_ld_vld(i_ld_vld), .i_ld_robIdx(i_ld_robIdx), .i_ld_paddr(i_ld_paddr),
        .i_ld_mask(i_ld_mask), .i_ld_foldpc(i_ld_foldpc), .o_full(o_full),
        .i_st_vld(i_st_vld), .i_st_robIdx(i_st_robIdx), .i_st_paddr(i_st_paddr),
        .i_st_mask(i_st_mask), .i_st_foldpc(i_st_foldpc),
        .i_commit_vld(i_commit_vld), .i_commit_robIdx(i_commit_robIdx),
        .i_squash(i_squash), .i_squash_robIdx(i_squash_robIdx),
        .o_violation(o_violation), .o_vio_store_foldpc(o_vio_store_foldpc),
        .o_vio_load_foldpc(o_vio_load_foldpc), .o_vio_load_robIdx(o_vio_load_robIdx),
        .o_vio_count(o_vio_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t vio(input logic [9:0] s, input logic [9:0] l, input logic [6:0] r);
        exp_t e;
        e.vio = 1'b1; e.sfpc = s; e.lfpc = l; e.lrob = r;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_ld_vld = 1'b0; i_ld_robIdx = 7'h00; i_ld_paddr = 40'h0; i_ld_mask = 8'h00; i_ld_foldpc = 10'h000;
        i_st_vld = 1'b0; i_st_robIdx = 7'h00; i_st_paddr = 40'h0; i_st_mask = 8'h00; i_st_foldpc = 10'h000;
        i_commit_vld = 1'b0; i_commit_robIdx = 7'h00;
        i_squash = 1'b0; i_squash_robIdx = 7'h00;
    endtask

    task automatic set_ld(input logic [6:0] r, input logic [39:0] a, input logic [7:0] m, input logic [9:0] f);
        i_ld_vld = 1'b1; i_ld_robIdx = r; i_ld_paddr = a; i_ld_mask = m; i_ld_foldpc = f;
    endtask

    task automatic set_st(input logic [6:0] r, input logic [39:0] a, input logic [7:0] m, input logic [9:0] f);
        i_st_vld = 1'b1; i_st_robIdx = r; i_st_paddr = a; i_st_mask = m; i_st_foldpc = f;
    endtask

    task automatic set_cm(input logic [6:0] r);
        i_commit_vld = 1'b1; i_commit_robIdx = r;
    endtask

    task automatic set_sq(input logic [6:0] r);
        i_squash = 1'b1; i_squash_robIdx = r;
    endtask

    // One clock: queue the expected report, advance, then pop and compare.
    task automatic tick(input exp_t e);
        exp_t x;
        sb_q.push_back(e);
        if (e.vio) exp_cnt++;
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        chk("violation", {31'd0, o_violation}, {31'd0, x.vio});
        if (x.vio) begin
            chk("store_foldpc", {22'd0, o_vio_store_foldpc}, {22'd0, x.sfpc});
            chk("load_foldpc", {22'd0, o_vio_load_foldpc}, {22'd0, x.lfpc});
            chk("load_robIdx", {25'd0, o_vio_load_robIdx}, {25'd0, x.lrob});
        end
`ifdef MEM_VIO_STAT_EN
        chk("vio_count", o_vio_count, exp_cnt);
`else
        chk("vio_count", o_vio_count, 32'd0);
`endif
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #12;
        chk("rst_violation", {31'd0, o_violation}, 32'd0);
        chk("rst_full", {31'd0, o_full}, 32'd0);
        chk("rst_count", o_vio_count, 32'd0);
        chk("rst_load_robIdx", {25'd0, o_vio_load_robIdx}, 32'd0);
        rst = 1'b1;

        // Basic overlap: older store hits younger load.
        set_ld(7'h05, 40'h1000, 8'h0F, 10'h02A); tick(NOV);
        set_st(7'h03, 40'h1000, 8'h01, 10'h011); tick(vio(10'h011, 10'h02A, 7'h05));
        set_sq(7'h05); tick(NOV);

        // No byte overlap, store younger, then commit+store uses pre-commit contents.
        set_ld(7'h05, 40'h1000, 8'h0F, 10'h02A); tick(NOV);
        set_st(7'h03, 40'h1000, 8'hF0, 10'h011); tick(NOV);
        set_st(7'h07, 40'h1000, 8'h0F, 10'h011); tick(NOV);
        set_cm(7'h05); set_st(7'h03, 40'h1000, 8'h01, 10'h011); tick(vio(10'h011, 10'h02A, 7'h05));
        set_sq(7'h05); tick(NOV);

        // Oldest of two matching loads, suppression in WAIT_FLUSH, squash clears both.
        set_ld(7'h06, 40'h2008, 8'hFF, 10'h031); tick(NOV);
        set_ld(7'h04, 40'h2008, 8'hFF, 10'h032); tick(NOV);
        set_st(7'h02, 40'h2008, 8'h01, 10'h012); tick(vio(10'h012, 10'h032, 7'h04));
        set_st(7'h02, 40'h2008, 8'h01, 10'h012); tick(NOV);
        set_sq(7'h04); tick(NOV);
        set_st(7'h02, 40'h2008, 8'h01, 10'h012); tick(NOV);

        // Same-cycle incoming load participates.
        set_ld(7'h08, 40'h3000, 8'h01, 10'h033); set_st(7'h07, 40'h3000, 8'h01, 10'h013);
        tick(vio(10'h013, 10'h033, 7'h08));
        set_sq(7'h08); tick(NOV);

        // Wrap flag; store address low bits ignored.
        set_ld(7'h41, 40'h4000, 8'h0F, 10'h034); tick(NOV);
        set_st(7'h3E, 40'h4005, 8'h0F, 10'h014); tick(vio(10'h014, 10'h034, 7'h41));
        set_sq(7'h41); tick(NOV);

        // Fill the table.
        for (int i = 0; i < 16; i++) begin
            set_ld(7'h10 + i[6:0], 40'h8000 + 40'(i * 8), 8'h01, i[9:0]);
            tick(NOV);
            if (i == 14) chk("full_at_15", {31'd0, o_full}, 32'd0);
        end
        chk("full_at_16", {31'd0, o_full}, 32'd1);
        set_cm(7'h10); tick(NOV);
        chk("full_after_commit", {31'd0, o_full}, 32'd0);
        set_sq(7'h1A); set_st(7'h1A, 40'h8058, 8'h01, 10'h015); tick(NOV);
        set_st(7'h15, 40'h8058, 8'h01, 10'h015); tick(NOV);
        set_st(7'h15, 40'h8048, 8'h01, 10'h015); tick(vio(10'h015, 10'h009, 7'h19));
        set_sq(7'h10); tick(NOV);
        chk("full_after_squash", {31'd0, o_full}, 32'd0);

        // Asynchronous reset while a pulse is on the outputs.
        set_ld(7'h20, 40'h9000, 8'hFF, 10'h03F); tick(NOV);
        set_st(7'h1F, 40'h9000, 8'h01, 10'h016); tick(vio(10'h016, 10'h03F, 7'h20));
        rst = 1'b0;
        #2;
        exp_cnt = 0;
        chk("async_rst_violation", {31'd0, o_violation}, 32'd0);
        chk("async_rst_count", o_vio_count, 32'd0);
        chk("async_rst_full", {31'd0, o_full}, 32'd0);
        rst = 1'b1;
        tick(NOV);
        set_st(7'h1F, 40'h9000, 8'h01, 10'h016); tick(NOV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
